// File: rtl/totient_sweep_engine.sv
// Sweeps n (up or triangle) and computes Euler's phi(n) with a subtractive-GCD FSM.
// Optional TOTIENT_PRIME_FLAG_EN adds a registered out_prime flag.
module totient_sweep_engine #(
  parameter int WIDTH = 4,
  parameter int MODE  = 1
) (
  input  logic             clk_0,
  input  logic             R,
  input  logic             run,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_phi,
  output logic [6:0]       out_seg,
  output logic             busy
`ifdef TOTIENT_PRIME_FLAG_EN
  , output logic           out_prime
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_GCD   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef TOTIENT_PRIME_FLAG_EN
  localparam logic [WIDTH-1:0] TWO = {{(WIDTH-2){1'b0}}, 2'b10};
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] n, k, a, b, cnt;
  logic             dir_up;

  logic [WIDTH-1:0] cnt_nxt, fin_phi, n_adv;
  logic [WIDTH+3:0] phi_ext;
  logic             fin, dir_adv;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
    endcase
  endfunction

  // Count this k as coprime when the GCD converged on 1.
  assign cnt_nxt = cnt + {{(WIDTH-1){1'b0}}, (a == ONE)};
  assign fin     = ((state == S_START) && (n == '0)) ||
                   ((state == S_GCD) && (a == b) && (k == n));
  assign fin_phi = (state == S_GCD) ? cnt_nxt : '0;
  assign phi_ext = {4'b0000, fin_phi};
  assign busy    = (state == S_START) || (state == S_GCD);

  // Triangle mode repeats each endpoint once while the direction flips.
  always_comb begin
    n_adv   = n + ONE;
    dir_adv = dir_up;
    if (MODE == 1) begin
      if (dir_up) begin
        if (&n) begin
          n_adv   = n;
          dir_adv = 1'b0;
        end
      end else if (n == '0) begin
        n_adv   = n;
        dir_adv = 1'b1;
      end else begin
        n_adv = n - ONE;
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (R) begin
      state     <= S_IDLE;
      n         <= '0;
      dir_up    <= 1'b1;
      k         <= '0;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_n     <= '0;
      out_phi   <= '0;
      out_seg   <= 7'h7E;
`ifdef TOTIENT_PRIME_FLAG_EN
      out_prime <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_START;
        S_START: begin
          k     <= ONE;
          a     <= n;
          b     <= ONE;
          cnt   <= '0;
          state <= (n == '0) ? S_DONE : S_GCD;
        end
        S_GCD: begin
          if (a > b)      a <= a - b;
          else if (b > a) b <= b - a;
          else begin
            cnt <= cnt_nxt;
            if (k == n) state <= S_DONE;
            else begin
              k <= k + ONE;
              a <= n;
              b <= k + ONE;
            end
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            n         <= n_adv;
            dir_up    <= dir_adv;
            state     <= run ? S_START : S_IDLE;
          end
        end
      endcase
      if (fin) begin
        out_valid <= 1'b1;
        out_n     <= n;
        out_phi   <= fin_phi;
        out_seg   <= hex7(phi_ext[3:0]);
`ifdef TOTIENT_PRIME_FLAG_EN
        out_prime <= (n >= TWO) && (fin_phi == n - ONE);
`endif
      end
    end
  end

endmodule

// File: tb/tb_totient_sweep_engine.sv
// Directed bench: triangle sweep (WIDTH=4) and wrapping up-count (WIDTH=3) instances.
module tb_totient_sweep_engine;

  logic clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  logic       R_t, run_t, rdy_t, vld_t, busy_t;
  logic [3:0] n_t, phi_t;
  logic [6:0] seg_t;
  logic       R_u, run_u, rdy_u, vld_u, busy_u;
  logic [2:0] n_u, phi_u;
  logic [6:0] seg_u;
`ifdef TOTIENT_PRIME_FLAG_EN
  logic       prime_t, prime_u;
`endif

  totient_sweep_engine #(.WIDTH(4), .MODE(1)) u_tri (
    .clk_0(clk_0), .R(R_t), .run(run_t), .out_ready(rdy_t), .out_valid(vld_t),
    .out_n(n_t), .out_phi(phi_t), .out_seg(seg_t), .busy(busy_t)
`ifdef TOTIENT_PRIME_FLAG_EN
    , .out_prime(prime_t)
`endif
  );

  totient_sweep_engine #(.WIDTH(3), .MODE(0)) u_up (
    .clk_0(clk_0), .R(R_u), .run(run_u), .out_ready(rdy_u), .out_valid(vld_u),
    .out_n(n_u), .out_phi(phi_u), .out_seg(seg_u), .busy(busy_u)
`ifdef TOTIENT_PRIME_FLAG_EN
    , .out_prime(prime_u)
`endif
  );

  typedef struct {
    int         n;
    int         phi;
    logic [6:0] seg;
    bit         prime;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_vld_t(output int cyc);
    cyc = 0;
    do begin @(negedge clk_0); cyc++; end while (!vld_t && cyc < 300);
    check("tri_valid_timeout", {31'd0, vld_t}, 32'd1);
  endtask

  task automatic wait_vld_u(output int cyc);
    cyc = 0;
    do begin @(negedge clk_0); cyc++; end while (!vld_u && cyc < 300);
    check("up_valid_timeout", {31'd0, vld_u}, 32'd1);
  endtask

  initial begin
    int         phi_tab [16];
    logic [6:0] seg_tab [16];
    logic [15:0] prime_mask;
    vec_t       tri_tab [34];
    int         cyc;
    int         nn;

    phi_tab = '{0, 1, 1, 2, 2, 4, 2, 6, 4, 6, 4, 10, 4, 12, 6, 8};
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    prime_mask = 16'h28AC;  // n = 2,3,5,7,11,13
    for (int i = 0; i < 34; i++) begin
      if (i < 16)       nn = i;
      else if (i == 16) nn = 15;
      else if (i < 32)  nn = 31 - i;
      else if (i == 32) nn = 0;
      else              nn = 1;
      tri_tab[i].n     = nn;
      tri_tab[i].phi   = phi_tab[nn];
      tri_tab[i].seg   = seg_tab[phi_tab[nn]];
      tri_tab[i].prime = prime_mask[nn];
    end

    R_t = 1'b1; run_t = 1'b0; rdy_t = 1'b0;
    R_u = 1'b1; run_u = 1'b0; rdy_u = 1'b0;
    repeat (2) @(negedge clk_0);
    check("rst_valid", {31'd0, vld_t}, 32'd0);
    check("rst_n",     {28'd0, n_t},   32'd0);
    check("rst_phi",   {28'd0, phi_t}, 32'd0);
    check("rst_seg",   {25'd0, seg_t}, 32'h7E);
    check("rst_busy",  {31'd0, busy_t}, 32'd0);

    // Triangle sweep with a backpressure window on the first n=9 result.
    R_t = 1'b0; run_t = 1'b1; rdy_t = 1'b1;
    for (int i = 0; i < 34; i++) begin
      wait_vld_t(cyc);
      if (i == 2) check("lat_n2", cyc, 32'd5);
      check($sformatf("tri_n[%0d]", i),   {28'd0, n_t},   tri_tab[i].n);
      check($sformatf("tri_phi[%0d]", i), {28'd0, phi_t}, tri_tab[i].phi);
      check($sformatf("tri_seg[%0d]", i), {25'd0, seg_t}, {25'd0, tri_tab[i].seg});
`ifdef TOTIENT_PRIME_FLAG_EN
      check($sformatf("tri_prime[%0d]", i), {31'd0, prime_t}, {31'd0, tri_tab[i].prime});
`endif
      if (i == 9) begin
        rdy_t = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk_0);
          check("bp_valid", {31'd0, vld_t}, 32'd1);
          check("bp_n",     {28'd0, n_t},   32'd9);
          check("bp_phi",   {28'd0, phi_t}, 32'd6);
          check("bp_seg",   {25'd0, seg_t}, 32'h5F);
        end
        rdy_t = 1'b1;
        @(negedge clk_0);
        rdy_t = 1'b0;
        check("bp_release", {31'd0, vld_t}, 32'd0);
      end else begin
        rdy_t = 1'b1;
      end
    end

    // Reset in the middle of a GCD with run held high.
    cyc = 0;
    do begin @(negedge clk_0); cyc++; end while (!busy_t && cyc < 50);
    check("pre_rst_busy", {31'd0, busy_t}, 32'd1);
    @(negedge clk_0);
    @(negedge clk_0);
    R_t = 1'b1;
    repeat (2) @(negedge clk_0);
    check("midrst_valid", {31'd0, vld_t}, 32'd0);
    check("midrst_n",     {28'd0, n_t},   32'd0);
    check("midrst_phi",   {28'd0, phi_t}, 32'd0);
    check("midrst_seg",   {25'd0, seg_t}, 32'h7E);
    check("midrst_busy",  {31'd0, busy_t}, 32'd0);
    R_t = 1'b0; run_t = 1'b0;
    repeat (4) @(negedge clk_0);
    check("idle_busy",  {31'd0, busy_t}, 32'd0);
    check("idle_valid", {31'd0, vld_t},  32'd0);
    run_t = 1'b1;
    wait_vld_t(cyc);
    check("after_rst_n",   {28'd0, n_t},   32'd0);
    check("after_rst_phi", {28'd0, phi_t}, 32'd0);

    // Wrapping up-count, WIDTH=3; run dropped during the n=7 computation.
    R_u = 1'b0; run_u = 1'b1; rdy_u = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_vld_u(cyc);
      check($sformatf("up_n[%0d]", i),   {29'd0, n_u},   i);
      check($sformatf("up_phi[%0d]", i), {29'd0, phi_u}, phi_tab[i]);
      check($sformatf("up_seg[%0d]", i), {25'd0, seg_u}, {25'd0, seg_tab[phi_tab[i]]});
    end
    @(negedge clk_0);
    check("up_busy_n7", {31'd0, busy_u}, 32'd1);
    run_u = 1'b0; rdy_u = 1'b0;
    wait_vld_u(cyc);
    check("up_n7",   {29'd0, n_u},   32'd7);
    check("up_phi7", {29'd0, phi_u}, 32'd6);
    check("up_seg7", {25'd0, seg_u}, 32'h5F);
    repeat (5) @(negedge clk_0);
    check("up_hold_valid", {31'd0, vld_u}, 32'd1);
    check("up_hold_n",     {29'd0, n_u},   32'd7);
    rdy_u = 1'b1;
    @(negedge clk_0);
    rdy_u = 1'b0;
    check("up_accept", {31'd0, vld_u}, 32'd0);
    repeat (5) @(negedge clk_0);
    check("up_idle_busy",  {31'd0, busy_u}, 32'd0);
    check("up_idle_valid", {31'd0, vld_u},  32'd0);
    run_u = 1'b1;
    wait_vld_u(cyc);
    check("up_wrap_n",   {29'd0, n_u},   32'd0);
    check("up_wrap_phi", {29'd0, phi_u}, 32'd0);
    check("up_wrap_seg", {25'd0, seg_u}, 32'h7E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/totient_sweep_engine.md
Name: totient_sweep_engine

Overview:
- Parametrised successor to the 4-bit ripple-counter/ROM totient display.
- Sweeps n over a WIDTH-bit range in up or triangle mode and computes Euler's totient phi(n) at run time, using a subtractive-GCD state machine instead of a lookup table.
- Presents {n, phi(n), seven-segment code of phi[3:0]} on a valid/ready output.
- Fully synchronous, single clock domain. Sits between the board clock/reset and the display/readout logic.

Parameters:
- WIDTH, 4, bit width of n, k, GCD operands and phi (phi(n) <= n < 2^WIDTH); legal range 2..16.
- MODE, 1, sweep mode: 0 = up (wrapping), 1 = triangle (up then down).

Ports:
- clk_0  input  1  system clock; all state changes on rising edge.
- R  input  1  reset, synchronous, active-high.
- run  input  1  permit start of a new computation / sweep advance.
- out_ready  input  1  consumer accepts result when high with out_valid.
- out_valid  output  1  result registers hold a completed result.
- out_n  output  WIDTH  n of current result.
- out_phi  output  WIDTH  phi(n).
- out_seg  output  7  abcdefg segment code of out_phi[3:0] as a hex digit; bit6 = a, bit0 = g; 1 = segment lit.
- busy  output  1  high in START or GCD state.

Behaviour:
- Reset (R=1 at an edge):
  - state = IDLE; n = 0; sweep direction = up.
  - out_valid = 0, out_n = 0, out_phi = 0, out_seg = 7'b1111110, busy = 0.
  - Reset overrides everything, including mid-computation and mid-handshake.
- IDLE:
  - run=1 -> START.
  - Otherwise hold.
- START (1 cycle):
  - k = 1, a = n, b = 1, cnt = 0.
  - If n == 0 -> DONE with phi = 0.
  - Else -> GCD.
- GCD (one cycle per step):
  - If a > b: a = a - b. If b > a: b = b - a.
  - If a == b: cnt = cnt + (a == 1).
    - If k == n -> DONE.
    - Else k = k + 1, a = n, b = k + 1, stay in GCD.
  - Cycles spent in GCD for a given k = (number of subtractions for gcd(n,k)) + 1.
- DONE entry:
  - out_n = n, out_phi = final cnt (including the last increment), out_seg = hex decode, out_valid = 1.
  - Outputs are registered and stable while out_valid=1 and out_ready=0.
- DONE:
  - On out_valid && out_ready at an edge: out_valid = 0, advance n.
  - Then run=1 -> START, run=0 -> IDLE.
- Sweep advance:
  - MODE 0: n = n + 1 modulo 2^WIDTH.
  - MODE 1: sequence 0, 1, ..., max, max, max-1, ..., 0, 0, 1, ... Each endpoint is produced twice; direction flips on the endpoint repeat.
- Stalls and run:
  - run deasserted mid-computation does not abort; the result completes and is held.
  - Subtractions never underflow; operands are always >= 1 in GCD.
- Hex decode (abcdefg):
  - 0 7E, 1 30, 2 6D, 3 79, 4 33, 5 5B, 6 5F, 7 70
  - 8 7F, 9 7B, A 77, b 1F, C 4E, d 3D, E 4F, F 47

Optional Feature:
- Macro: TOTIENT_PRIME_FLAG_EN.
- When defined:
  - Adds output port out_prime (1 bit), registered with the other outputs at DONE entry.
  - out_prime = 1 iff n >= 2 and phi == n - 1.
  - Reset value 0.
- When undefined: port absent; no other behaviour change.

Test Plan:
- Reset: assert R for 2 cycles while run=1 and mid-GCD -> next cycle out_valid=0, out_n=0, out_phi=0, out_seg=7E, busy=0; state returns to IDLE.
- n=0 and n=1, WIDTH=4, out_ready=1: results (0,0,seg 7E) then (1,1,seg 30).
- Latency, n=2: START entered at edge t -> GCD cycles at t+1..t+3 -> out_valid=1 after edge t+4 with phi=1, seg=30.
- Full sweep, MODE=1, WIDTH=4, out_ready=1:
  - out_n order 0..15, 15, 14..0, 0, 1.
  - phi values: 0,1,1,2,2,4,2,6,4,6,4,10,4,12,6,8.
  - With TOTIENT_PRIME_FLAG_EN: out_prime=1 exactly at n = 2,3,5,7,11,13.
- Backpressure: hold out_ready=0 for 20 cycles after n=9 result -> out_n=9, out_phi=6, out_seg=5F stay stable, n does not advance. Single-cycle ready then advances to n=10, phi=4.
- MODE=0, WIDTH=3, run toggled low during n=7 computation -> result (7,6) completes and is held. After acceptance, engine idles until run=1, then produces n=0.
